// File: rtl/spiflash_pkg.sv
// Shared opcodes, FSM states and byte-lane helper for the BRAM-backed SPI flash emulator.
package spiflash_pkg;

  localparam logic [7:0] OP_READ       = 8'h03;
  localparam logic [7:0] OP_FAST_READ  = 8'h0B;
  localparam logic [7:0] OP_JEDEC_ID   = 8'h9F;
  localparam logic [7:0] OP_RELEASE_PD = 8'hAB;

  typedef enum logic [2:0] {CMD, ADDR, DUMMY, DATA, ID, IGNORE} state_e;

  // Little-endian lane select: lane 0 is word[7:0].
  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises csb/spiclk/io0 into the system clock domain and edge-detects spiclk.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic csb,
  input  logic spiclk,
  input  logic io0,
  output logic csb_s,
  output logic io0_s,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [SYNC_STAGES-1:0] csb_ff;
  logic [SYNC_STAGES-1:0] sclk_ff;
  logic [SYNC_STAGES-1:0] io0_ff;
  logic                   sclk_d;

  // csb chain resets low so a fresh csb high must be seen before the core arms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb_ff  <= '0;
      sclk_ff <= '0;
      io0_ff  <= '0;
      sclk_d  <= 1'b0;
    end else begin
      csb_ff  <= {csb_ff[SYNC_STAGES-2:0], csb};
      sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], spiclk};
      io0_ff  <= {io0_ff[SYNC_STAGES-2:0], io0};
      sclk_d  <= sclk_ff[SYNC_STAGES-1];
    end
  end

  assign csb_s     = csb_ff[SYNC_STAGES-1];
  assign io0_s     = io0_ff[SYNC_STAGES-1];
  assign sclk_rise = sclk_ff[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_ff[SYNC_STAGES-1] & sclk_d;

endmodule

// File: rtl/spiflash_bram_multi.sv
// SPI flash slave emulator serving read / fast read / JEDEC ID from a BRAM ROM image.
module spiflash_bram_multi
  import spiflash_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 24,
  parameter logic [31:0] ROM_BASE     = 32'h0000_0000,
  parameter int unsigned DUMMY_CYCLES = 8,
  parameter logic [23:0] JEDEC_ID     = 24'hEF4016,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        csb,
  input  logic        spiclk,
  input  logic        io0,
  output logic        io1,
  output logic [31:0] romcode_Addr_A,
  output logic        romcode_EN_A,
  output logic [3:0]  romcode_WEN_A,
  output logic [31:0] romcode_Din_A,
  input  logic [31:0] romcode_Dout_A,
  output logic        romcode_Clk_A,
  output logic        romcode_Rst_A,
  output logic        cmd_err
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned ID_W  = 5;

  logic csb_s, io0_s, sclk_rise, sclk_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (ap_clk),
    .rst_n    (ap_rst),
    .csb      (csb),
    .spiclk   (spiclk),
    .io0      (io0),
    .csb_s    (csb_s),
    .io0_s    (io0_s),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall)
  );

  state_e               state_q, state_d;
  logic                 armed_q, armed_d;
  logic                 fast_q, fast_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [6:0]           cmd_q, cmd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [2:0]           bit_q, bit_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [31:0]          word_q, word_d;
  logic                 io1_d, en_d, err_d;
  logic [31:0]          raddr_d;
  logic [7:0]           cmd_next, cur_byte;
  logic [ADDR_BITS-1:0] addr_next, addr_inc;

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    fast_d    = fast_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    bit_d     = bit_q;
    id_d      = id_q;
    word_d    = word_q;
    rd_pend_d = romcode_EN_A;
    io1_d     = io1;
    en_d      = 1'b0;
    err_d     = 1'b0;
    raddr_d   = romcode_Addr_A;
    cmd_next  = {cmd_q, io0_s};
    addr_next = {addr_q[ADDR_BITS-2:0], io0_s};
    addr_inc  = addr_q + ADDR_BITS'(1);
    cur_byte  = sel_byte(word_q, addr_q[1:0]);

    if (rd_pend_q) word_d = romcode_Dout_A;

    if (csb_s) begin
      // Deselect aborts everything, including a BRAM read in flight.
      state_d   = CMD;
      armed_d   = 1'b1;
      fast_d    = 1'b0;
      cmd_d     = '0;
      cnt_d     = '0;
      bit_d     = '0;
      id_d      = '0;
      word_d    = word_q;
      rd_pend_d = 1'b0;
      io1_d     = 1'b0;
    end else begin
      case (state_q)
        CMD: begin
          io1_d = 1'b0;
          if (sclk_rise && armed_q) begin
            cmd_d = cmd_next[6:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              cnt_d = '0;
              case (cmd_next)
                OP_READ:       state_d = ADDR;
                OP_FAST_READ:  begin state_d = ADDR; fast_d = 1'b1; end
                OP_JEDEC_ID:   begin state_d = ID; id_d = ID_W'(23); end
                OP_RELEASE_PD: state_d = IGNORE;
                default:       begin state_d = IGNORE; err_d = 1'b1; end
              endcase
            end
          end
        end
        ADDR: begin
          io1_d = 1'b0;
          if (sclk_rise) begin
            addr_d = addr_next;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ADDR_BITS - 1)) begin
              cnt_d   = '0;
              bit_d   = 3'd7;
              en_d    = 1'b1;
              raddr_d = ROM_BASE + 32'({addr_next[ADDR_BITS-1:2], 2'b00});
              state_d = (fast_q && DUMMY_CYCLES != 0) ? DUMMY : DATA;
            end
          end
        end
        DUMMY: begin
          io1_d = 1'b0;
          if (sclk_rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
              cnt_d   = '0;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          // Leaving the last lane of a word prefetches the next word, hiding BRAM latency.
          if (sclk_fall) begin
            io1_d = cur_byte[bit_q];
            bit_d = bit_q - 3'd1;
            if (bit_q == 3'd0) begin
              addr_d = addr_inc;
              if (addr_inc[1:0] == 2'b00) begin
                en_d    = 1'b1;
                raddr_d = ROM_BASE + 32'({addr_inc[ADDR_BITS-1:2], 2'b00});
              end
            end
          end
        end
        ID: begin
          if (sclk_fall) begin
            io1_d = JEDEC_ID[id_q];
            id_d  = (id_q == '0) ? ID_W'(23) : id_q - ID_W'(1);
          end
        end
        IGNORE:  io1_d = 1'b0;
        default: state_d = CMD;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) begin
      state_q        <= CMD;
      armed_q        <= 1'b0;
      fast_q         <= 1'b0;
      rd_pend_q      <= 1'b0;
      cmd_q          <= '0;
      cnt_q          <= '0;
      addr_q         <= '0;
      bit_q          <= '0;
      id_q           <= '0;
      word_q         <= '0;
      io1            <= 1'b0;
      romcode_EN_A   <= 1'b0;
      romcode_Addr_A <= '0;
      cmd_err        <= 1'b0;
    end else begin
      state_q        <= state_d;
      armed_q        <= armed_d;
      fast_q         <= fast_d;
      rd_pend_q      <= rd_pend_d;
      cmd_q          <= cmd_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      bit_q          <= bit_d;
      id_q           <= id_d;
      word_q         <= word_d;
      io1            <= io1_d;
      romcode_EN_A   <= en_d;
      romcode_Addr_A <= raddr_d;
      cmd_err        <= err_d;
    end
  end

  assign romcode_WEN_A = 4'h0;
  assign romcode_Din_A = 32'h0;
  assign romcode_Clk_A = ap_clk;
  assign romcode_Rst_A = ~ap_rst;

endmodule

// File: tb/tb_spiflash_bram_multi.sv
// Directed bench for spiflash_bram_multi: default instance plus a 16-bit/offset-ROM instance.
`timescale 1ns/1ps
module tb_spiflash_bram_multi;
  import spiflash_pkg::*;

  localparam int HALF = 80;

  logic ap_clk, ap_rst, csb, spiclk, io0;
  logic        io1_a, en_a, clk_a, rst_a, err_a;
  logic [31:0] addr_a, din_a, dout_a;
  logic [3:0]  wen_a;
  logic        io1_b, en_b, clk_b, rst_b, err_b;
  logic [31:0] addr_b, din_b, dout_b;
  logic [3:0]  wen_b;

  int tests, failures;
  int en_cnt_a, err_cnt_a;
  logic [31:0] en_log_a[$];
  logic [31:0] en_log_b[$];
  bit sel_b;

  spiflash_bram_multi dut_a (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .csb(csb), .spiclk(spiclk), .io0(io0), .io1(io1_a),
    .romcode_Addr_A(addr_a), .romcode_EN_A(en_a), .romcode_WEN_A(wen_a), .romcode_Din_A(din_a),
    .romcode_Dout_A(dout_a), .romcode_Clk_A(clk_a), .romcode_Rst_A(rst_a), .cmd_err(err_a)
  );

  spiflash_bram_multi #(.ADDR_BITS(16), .ROM_BASE(32'h100)) dut_b (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .csb(csb), .spiclk(spiclk), .io0(io0), .io1(io1_b),
    .romcode_Addr_A(addr_b), .romcode_EN_A(en_b), .romcode_WEN_A(wen_b), .romcode_Din_A(din_b),
    .romcode_Dout_A(dout_b), .romcode_Clk_A(clk_b), .romcode_Rst_A(rst_b), .cmd_err(err_b)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // ROM image: byte at address b holds (b+1) mod 256, so word 0 = 32'h04030201.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [7:0] b0;
    b0 = a[7:0];
    return {b0 + 8'd4, b0 + 8'd3, b0 + 8'd2, b0 + 8'd1};
  endfunction

  always @(posedge ap_clk) begin
    if (en_a) dout_a <= rom_word(addr_a);
    if (en_b) dout_b <= rom_word(addr_b);
  end

  always @(negedge ap_clk) begin
    if (en_a) begin en_cnt_a++; en_log_a.push_back(addr_a); end
    if (en_b) en_log_b.push_back(addr_b);
    if (err_a) err_cnt_a++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic xfer_bit(input logic tx, output logic rx);
    io0 = tx;
    #(HALF);
    rx = sel_b ? io1_b : io1_a;
    spiclk = 1'b1;
    #(HALF);
    spiclk = 1'b0;
  endtask

  // Opcode, optional address, then nb clocked bytes; csb is left to the caller.
  task automatic shift_txn(input logic [7:0] op, input logic [31:0] addr, input int abits,
                           input int nb, output logic [63:0] rx);
    logic r;
    rx = '0;
    for (int i = 7; i >= 0; i--) xfer_bit(op[i], r);
    if (op == OP_READ || op == OP_FAST_READ)
      for (int i = abits - 1; i >= 0; i--) xfer_bit(addr[i], r);
    for (int n = 0; n < nb; n++)
      for (int i = 7; i >= 0; i--) begin
        xfer_bit(1'b0, r);
        rx = {rx[62:0], r};
      end
  endtask

  task automatic run_txn(input logic [7:0] op, input logic [31:0] addr, input int abits,
                         input int nb, output logic [63:0] rx);
    csb = 1'b0;
    #(HALF);
    shift_txn(op, addr, abits, nb, rx);
    #(HALF);
    csb = 1'b1;
    repeat (20) @(negedge ap_clk);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    int          nb;
    logic [63:0] exp;
    int          exp_en;
    int          exp_err;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [63:0] rx;
    logic [11:0] rx12;
    logic r;

    tests = 0; failures = 0; en_cnt_a = 0; err_cnt_a = 0; sel_b = 1'b0;
    ap_rst = 1'b0; csb = 1'b1; spiclk = 1'b0; io0 = 1'b0;
    dout_a = '0; dout_b = '0;

    vt[0] = '{8'h03, 32'h0, 7, 64'h0001020304050607, 2, 0};
    vt[1] = '{8'h0B, 32'h2, 5, 64'h0000000003040506, 2, 0};
    vt[2] = '{8'h9F, 32'h0, 6, 64'h0000EF4016EF4016, 0, 0};
    vt[3] = '{8'h5A, 32'h0, 4, 64'h0, 0, 1};
    vt[4] = '{8'h03, 32'h5, 2, 64'h0607, 1, 0};
    vt[5] = '{8'hAB, 32'h0, 2, 64'h0, 0, 0};
    vt[6] = '{8'h03, 32'h3, 2, 64'h0405, 2, 0};

    repeat (3) @(negedge ap_clk);
    check("reset io1", 64'(io1_a), 64'h0);
    check("reset en", 64'(en_a), 64'h0);
    check("reset addr", 64'(addr_a), 64'h0);
    check("reset cmd_err", 64'(err_a), 64'h0);
    check("reset state", 64'(dut_a.state_q), 64'(CMD));
    ap_rst = 1'b1;
    repeat (10) @(negedge ap_clk);

    for (int k = 0; k < 7; k++) begin
      en_cnt_a = 0; err_cnt_a = 0;
      run_txn(vt[k].op, vt[k].addr, 24, vt[k].nb, rx);
      check($sformatf("vec%0d data", k), rx, vt[k].exp);
      check($sformatf("vec%0d en_count", k), 64'(en_cnt_a), 64'(vt[k].exp_en));
      check($sformatf("vec%0d cmd_err", k), 64'(err_cnt_a), 64'(vt[k].exp_err));
    end

    // Full two-word read: reads issued at 0x0 then 0x4 in that order.
    en_log_a.delete();
    run_txn(OP_READ, 32'h0, 24, 8, rx);
    check("read8 data", rx, 64'h0102030405060708);
    if (en_log_a.size() >= 2) begin
      check("read8 en0 addr", 64'(en_log_a[0]), 64'h0);
      check("read8 en1 addr", 64'(en_log_a[1]), 64'h4);
    end else
      check("read8 en count", 64'(en_log_a.size()), 64'd2);

    // 16-bit address wrap with ROM offset on the second instance.
    sel_b = 1'b1;
    en_log_b.delete();
    run_txn(OP_READ, 32'hFFFE, 16, 4, rx);
    sel_b = 1'b0;
    check("wrap data", rx, 64'hFF000102);
    check("wrap en count", 64'(en_log_b.size()), 64'd2);
    if (en_log_b.size() >= 2) begin
      check("wrap en0 addr", 64'(en_log_b[0]), 64'h100FC);
      check("wrap en1 addr", 64'(en_log_b[1]), 64'h100);
    end

    // Abort after 12 data bits of a read from 0x6 (bytes 07 08).
    csb = 1'b0;
    #(HALF);
    shift_txn(OP_READ, 32'h6, 24, 0, rx);
    rx12 = '0;
    for (int i = 0; i < 12; i++) begin
      xfer_bit(1'b0, r);
      rx12 = {rx12[10:0], r};
    end
    check("abort bits", 64'(rx12), 64'h070);
    #(HALF);
    check("abort io1 before csb", 64'(io1_a), 64'h1);
    csb = 1'b1;
    repeat (6) @(negedge ap_clk);
    check("abort io1 after csb", 64'(io1_a), 64'h0);
    check("abort state", 64'(dut_a.state_q), 64'(CMD));
    repeat (10) @(negedge ap_clk);

    // Reset during the address phase, then csb held low: no command may be recognised.
    csb = 1'b0;
    #(HALF);
    for (int i = 7; i >= 0; i--) xfer_bit(OP_READ[i], r);
    for (int i = 0; i < 8; i++) xfer_bit(1'b0, r);
    check("pre-reset state", 64'(dut_a.state_q), 64'(ADDR));
    @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
    check("async reset state", 64'(dut_a.state_q), 64'(CMD));
    check("async reset io1", 64'(io1_a), 64'h0);
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b1;
    repeat (5) @(negedge ap_clk);
    en_cnt_a = 0;
    shift_txn(OP_READ, 32'h0, 24, 1, rx);
    check("no fresh csb data", rx, 64'h0);
    check("no fresh csb en", 64'(en_cnt_a), 64'h0);
    #(HALF);
    csb = 1'b1;
    repeat (20) @(negedge ap_clk);
    run_txn(OP_READ, 32'h0, 24, 1, rx);
    check("post-reset read", rx, 64'h01);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
